// File: rtl/idli_pkg.sv
// Shared types for the idli execute stage: slice-serial operand widths,
// ALU/compare opcodes and the flag bundle used by compare/branch logic.
package idli_pkg;

  localparam int unsigned SLICE_W  = 4;
  localparam int unsigned N_SLICES = 4;

  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [1:0]         ctr_t;

  localparam ctr_t CTR_FIRST = 2'd0;
  localparam ctr_t CTR_LAST  = 2'd3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_AND = 2'd1,
    ALU_OR  = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  // Encoding 7 is unused; evaluating it yields a false predicate.
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_LTU = 3'd3,
    CMP_GE  = 3'd4,
    CMP_GEU = 3'd5,
    CMP_ANY = 3'd6
  } cmp_op_t;

  // Flags of a completed 16b operation, taken at the final slice.
  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } alu_flags_t;

endpackage

// File: rtl/idli_cmp_eval.sv
// Combinational predicate evaluation: final flags + compare op -> one bit.
module idli_cmp_eval
  import idli_pkg::*;
(
  input  alu_flags_t flags_i,
  input  cmp_op_t    cmp_op_i,
  output logic       p_o
);

  // Map each compare condition onto the flags of (lhs - rhs), or of
  // (lhs & rhs) for ANY.
  always_comb begin
    p_o = 1'b0;
    case (cmp_op_i)
      CMP_EQ:  p_o = flags_i.z;
      CMP_NE:  p_o = ~flags_i.z;
      CMP_LT:  p_o = flags_i.n ^ flags_i.v;
      CMP_GE:  p_o = ~(flags_i.n ^ flags_i.v);
      CMP_LTU: p_o = ~flags_i.c;
      CMP_GEU: p_o = flags_i.c;
      CMP_ANY: p_o = ~flags_i.z;
      default: p_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/idli_alu.sv
// Slice-serial 16b ALU/comparator. One 4b slice per cycle, least significant
// slice first (ctr 0). o_res is combinational; a compare produces a registered
// predicate pulse the cycle after its ctr 3 slice.
//
// Handshake: there is no backpressure. i_valid high means a slice is presented
// this cycle and is consumed at the next clock edge; i_valid low flushes any
// in-flight operation. o_p_valid is a single-cycle pulse with no ready.
module idli_alu
  import idli_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_valid,
  input  ctr_t    i_ctr,
  input  alu_op_t i_op,
  input  logic    i_sub,
  input  logic    i_cmp,
  input  cmp_op_t i_cmp_op,
  input  slice_t  i_lhs,
  input  slice_t  i_rhs,
  output slice_t  o_res,
  output logic    o_p_valid,
  output logic    o_p
);

  // Inter-slice state
  logic carry_q, carry_d;
  logic z_q, z_d;
  logic active_q, active_d;
  ctr_t ctr_exp_q, ctr_exp_d;
  logic p_valid_q, p_valid_d;
  logic p_q, p_d;

  // Slice datapath
  alu_op_t    eff_op;
  logic       eff_sub;
  logic       cin;
  slice_t     rhs_eff;
  logic [4:0] sum;
  slice_t     res;
  logic       cout;
  logic       res_zero;
  logic       in_seq;
  logic       starting;
  logic       last;
  alu_flags_t flags;
  logic       pred;

  // Compares reuse the adder as lhs - rhs, except ANY which is an AND test.
  always_comb begin
    eff_op  = i_op;
    eff_sub = (i_op == ALU_ADD) && i_sub;
    if (i_cmp) begin
      if (i_cmp_op == CMP_ANY) begin
        eff_op  = ALU_AND;
        eff_sub = 1'b0;
      end else begin
        eff_op  = ALU_ADD;
        eff_sub = 1'b1;
      end
    end
  end

  // One 4b slice: 5b add with carry chained through carry_q, or bitwise op.
  always_comb begin
    cin     = (i_ctr == CTR_FIRST) ? eff_sub : carry_q;
    rhs_eff = eff_sub ? ~i_rhs : i_rhs;
    sum     = {1'b0, i_lhs} + {1'b0, rhs_eff} + {4'b0000, cin};
    res     = '0;
    cout    = 1'b0;
    case (eff_op)
      ALU_ADD: begin
        res  = sum[3:0];
        cout = sum[4];
      end
      ALU_AND: res = i_lhs & i_rhs;
      ALU_OR:  res = i_lhs | i_rhs;
      ALU_XOR: res = i_lhs ^ i_rhs;
      default: res = '0;
    endcase
  end

  assign o_res    = res;
  assign res_zero = (res == '0);
  assign starting = (i_ctr == CTR_FIRST);
  assign last     = (i_ctr == CTR_LAST);
  // Slice continues a sequence that began at ctr 0 with no gaps.
  assign in_seq   = active_q && (i_ctr == ctr_exp_q);

  // Final-slice flags; z_q already covers slices 0..2.
  always_comb begin
    flags.z = z_q && res_zero;
    flags.n = res[3];
    flags.v = (i_lhs[3] == ~i_rhs[3]) && (res[3] != i_lhs[3]);
    flags.c = cout;
  end

  idli_cmp_eval u_cmp_eval (
    .flags_i  (flags),
    .cmp_op_i (i_cmp_op),
    .p_o      (pred)
  );

  // Next-state for carry, zero accumulator, sequence tracking and predicate.
  always_comb begin
    carry_d   = carry_q;
    z_d       = z_q;
    active_d  = active_q;
    ctr_exp_d = ctr_exp_q;
    p_valid_d = 1'b0;
    p_d       = p_q;
    if (!i_valid) begin
      carry_d   = 1'b0;
      z_d       = 1'b0;
      active_d  = 1'b0;
      ctr_exp_d = CTR_FIRST;
    end else begin
      if (!last && (eff_op == ALU_ADD)) begin
        carry_d = cout;
      end
      z_d       = starting ? res_zero : (z_q && res_zero);
      active_d  = (starting || in_seq) && !last;
      ctr_exp_d = ctr_t'(i_ctr + 2'd1);
      if (last && in_seq && i_cmp) begin
        p_valid_d = 1'b1;
        p_d       = pred;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      carry_q   <= 1'b0;
      z_q       <= 1'b0;
      active_q  <= 1'b0;
      ctr_exp_q <= CTR_FIRST;
      p_valid_q <= 1'b0;
      p_q       <= 1'b0;
    end else begin
      carry_q   <= carry_d;
      z_q       <= z_d;
      active_q  <= active_d;
      ctr_exp_q <= ctr_exp_d;
      p_valid_q <= p_valid_d;
      p_q       <= p_d;
    end
  end

  assign o_p_valid = p_valid_q;
  assign o_p       = p_q;

endmodule
